// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 4-stage flintRV pipeline: EXEC operand forwarding,
// load-use/branch handling, mul/div interlock FSM and data-memory wait watchdog.
module pipe_hazard_ctrl #(
  parameter int REGW        = 5,
  parameter int MD_LAT      = 32,
  parameter int MEM_TIMEOUT = 63,
  parameter int CNTW        = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] EXEC_rs1,
  input  logic [REGW-1:0] EXEC_rs2,
  input  logic [REGW-1:0] MEM_rd,
  input  logic [REGW-1:0] WB_rd,
  input  logic            MEM_rd_reg_write,
  input  logic            WB_rd_reg_write,
  input  logic            FETCH_valid,
  input  logic [REGW-1:0] FETCH_rs1,
  input  logic [REGW-1:0] FETCH_rs2,
  input  logic [REGW-1:0] EXEC_rd,
  input  logic            EXEC_mem2reg,
  input  logic            EXEC_muldiv,
  input  logic            MEM_req,
  input  logic            MEM_valid,
  input  logic            BRA,
  input  logic            JMP,
  output logic [1:0]      FWD_rs1,
  output logic [1:0]      FWD_rs2,
  output logic            FETCH_stall,
  output logic            EXEC_stall,
  output logic            EXEC_flush,
  output logic            MEM_flush,
  output logic            MD_start,
  output logic            MD_busy,
  output logic            MEM_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] wcnt_q, wcnt_d;
  logic            err_q, err_d;
  logic            md_start;
  logic            mem_wait, md_hold, lu, br;

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] rs,
                                         input logic [REGW-1:0] mem_rd,
                                         input logic            mem_we,
                                         input logic [REGW-1:0] wb_rd,
                                         input logic            wb_we);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_we && (mem_rd != '0) && (mem_rd == rs))
      sel = 2'b10;
    else if (wb_we && (wb_rd != '0) && (wb_rd == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign FWD_rs1 = fwd_sel(EXEC_rs1, MEM_rd, MEM_rd_reg_write, WB_rd, WB_rd_reg_write);
  assign FWD_rs2 = fwd_sel(EXEC_rs2, MEM_rd, MEM_rd_reg_write, WB_rd, WB_rd_reg_write);

  assign mem_wait = MEM_req & ~MEM_valid;
  assign md_hold  = ((state_q == IDLE) & EXEC_muldiv) | (state_q == BUSY);
  assign lu       = FETCH_valid & EXEC_mem2reg & (EXEC_rd != '0) &
                    ((FETCH_rs1 == EXEC_rd) | (FETCH_rs2 == EXEC_rd));
  assign br       = (BRA | JMP) & ~mem_wait & ~md_hold;

  always_comb begin
    FETCH_stall = 1'b0;
    EXEC_stall  = 1'b0;
    EXEC_flush  = 1'b0;
    MEM_flush   = 1'b0;
    if (mem_wait) begin
      FETCH_stall = 1'b1;
      EXEC_stall  = 1'b1;
    end else if (md_hold) begin
      FETCH_stall = 1'b1;
      EXEC_stall  = 1'b1;
      MEM_flush   = 1'b1;
    end else if (br) begin
      EXEC_flush  = 1'b1;
    end else if (lu) begin
      FETCH_stall = 1'b1;
      EXEC_flush  = 1'b1;
    end
  end

  // The mul/div unit keeps counting through a memory wait; only the DONE exit waits for it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (EXEC_muldiv && !mem_wait) begin
          state_d  = BUSY;
          cnt_d    = CNTW'(MD_LAT - 1);
          md_start = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1))
          state_d = DONE;
      end
      DONE: begin
        if (!mem_wait)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wcnt_d = '0;
    if (mem_wait)
      wcnt_d = (wcnt_q == CNTW'(MEM_TIMEOUT)) ? wcnt_q : wcnt_q + CNTW'(1);
    err_d = err_q | (mem_wait & (wcnt_q == CNTW'(MEM_TIMEOUT)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  // Start pulse is suppressed while reset is held so the unit never launches from reset.
  assign MD_start = md_start & ~rst;
  assign MD_busy  = (state_q != IDLE);
  assign MEM_err  = err_q;

endmodule
